// File: rtl/branch_resolve_unit_if.sv
// Bundle of the execute-side branch request and the resolved redirect/mispredict
// response exchanged between the issue logic (master) and the resolution unit (slave).
interface branch_resolve_unit_if #(
    parameter int XLEN  = 64,
    parameter int PC_W  = 64,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   imm;
    logic              pred_taken;

    logic              out_valid;
    logic              taken;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   redirect_pc;
    logic              mispredict;
    logic              illegal;
    logic [CNT_W-1:0]  mispredict_cnt;

    modport master (
        output in_valid, stall, flush, funct3, rs1, rs2, pc, imm, pred_taken,
        input  out_valid, taken, target, redirect_pc, mispredict, illegal, mispredict_cnt
    );

    modport slave (
        input  in_valid, stall, flush, funct3, rs1, rs2, pc, imm, pred_taken,
        output out_valid, taken, target, redirect_pc, mispredict, illegal, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates RV64I conditional branches, computes
// the target and raises a registered redirect/mispredict pulse, in 1 or 2 stages.
module branch_resolve_unit #(
    parameter int XLEN   = 64,
    parameter int PC_W   = 64,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    branch_resolve_unit_if.slave bus
);

    localparam logic [PC_W-1:0]  PC_STEP = PC_W'(3'd4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [XLEN-1:0] rs1_s, rs2_s;
    logic [PC_W-1:0] pc_s, imm_s, tgt_s, pc4_s;
    logic            eq_s, slt_s, sltu_s, advance_s;

    // Entry being resolved this cycle: straight from the inputs or from stage 1
    logic            sel_valid_s, sel_eq_s, sel_slt_s, sel_sltu_s, sel_pred_s;
    logic            sel_taken_s, sel_illegal_s;
    logic [2:0]      sel_f3_s;
    logic [PC_W-1:0] sel_tgt_s, sel_pc4_s;

    logic             out_valid_q, out_valid_d, taken_q, taken_d;
    logic             mispredict_q, mispredict_d, illegal_q, illegal_d;
    logic [PC_W-1:0]  target_q, target_d, redirect_q, redirect_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign rs1_s     = bus.rs1;
    assign rs2_s     = bus.rs2;
    assign pc_s      = bus.pc;
    assign imm_s     = bus.imm;
    assign advance_s = ~bus.flush & ~bus.stall;

    // Raw comparisons and wrapping address arithmetic on the incoming branch
    always_comb begin
        eq_s   = (rs1_s == rs2_s);
        slt_s  = ($signed(rs1_s) < $signed(rs2_s));
        sltu_s = (rs1_s < rs2_s);
        tgt_s  = pc_s + imm_s;
        pc4_s  = pc_s + PC_STEP;
    end

    generate
        if (STAGES == 1) begin : g_one
            assign sel_valid_s = bus.in_valid;
            assign sel_eq_s    = eq_s;
            assign sel_slt_s   = slt_s;
            assign sel_sltu_s  = sltu_s;
            assign sel_f3_s    = bus.funct3;
            assign sel_tgt_s   = tgt_s;
            assign sel_pc4_s   = pc4_s;
            assign sel_pred_s  = bus.pred_taken;
        end else if (STAGES == 2) begin : g_two
            logic            s1_valid_q, s1_valid_d, s1_eq_q, s1_eq_d, s1_slt_q, s1_slt_d;
            logic            s1_sltu_q, s1_sltu_d, s1_pred_q, s1_pred_d;
            logic [2:0]      s1_f3_q, s1_f3_d;
            logic [PC_W-1:0] s1_tgt_q, s1_tgt_d, s1_pc4_q, s1_pc4_d;

            // Stage-1 capture; a branch arriving as the output takes a mispredict is wrong-path
            always_comb begin
                s1_valid_d = s1_valid_q;
                s1_eq_d    = s1_eq_q;
                s1_slt_d   = s1_slt_q;
                s1_sltu_d  = s1_sltu_q;
                s1_pred_d  = s1_pred_q;
                s1_f3_d    = s1_f3_q;
                s1_tgt_d   = s1_tgt_q;
                s1_pc4_d   = s1_pc4_q;
                if (bus.flush) begin
                    s1_valid_d = 1'b0;
                end else if (bus.stall) begin
                    s1_valid_d = s1_valid_q;
                end else begin
                    s1_valid_d = bus.in_valid & ~mispredict_d;
                    if (bus.in_valid) begin
                        s1_eq_d   = eq_s;
                        s1_slt_d  = slt_s;
                        s1_sltu_d = sltu_s;
                        s1_pred_d = bus.pred_taken;
                        s1_f3_d   = bus.funct3;
                        s1_tgt_d  = tgt_s;
                        s1_pc4_d  = pc4_s;
                    end else begin
                        s1_eq_d   = s1_eq_q;
                    end
                end
            end

            // Stage-1 register with synchronous reset
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    s1_valid_q <= 1'b0;
                    s1_eq_q    <= 1'b0;
                    s1_slt_q   <= 1'b0;
                    s1_sltu_q  <= 1'b0;
                    s1_pred_q  <= 1'b0;
                    s1_f3_q    <= 3'b000;
                    s1_tgt_q   <= {PC_W{1'b0}};
                    s1_pc4_q   <= {PC_W{1'b0}};
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_eq_q    <= s1_eq_d;
                    s1_slt_q   <= s1_slt_d;
                    s1_sltu_q  <= s1_sltu_d;
                    s1_pred_q  <= s1_pred_d;
                    s1_f3_q    <= s1_f3_d;
                    s1_tgt_q   <= s1_tgt_d;
                    s1_pc4_q   <= s1_pc4_d;
                end
            end

            assign sel_valid_s = s1_valid_q;
            assign sel_eq_s    = s1_eq_q;
            assign sel_slt_s   = s1_slt_q;
            assign sel_sltu_s  = s1_sltu_q;
            assign sel_f3_s    = s1_f3_q;
            assign sel_tgt_s   = s1_tgt_q;
            assign sel_pc4_s   = s1_pc4_q;
            assign sel_pred_s  = s1_pred_q;
        end else begin : g_bad
            $fatal(1, "branch_resolve_unit: STAGES must be 1 or 2");
        end
    endgenerate

    // Outcome select; 010/011 fall to the default and resolve not-taken
    always_comb begin
        sel_illegal_s = (sel_f3_s == 3'b010) || (sel_f3_s == 3'b011);
        case (sel_f3_s)
            3'b000:  sel_taken_s = sel_eq_s;
            3'b001:  sel_taken_s = ~sel_eq_s;
            3'b100:  sel_taken_s = sel_slt_s;
            3'b101:  sel_taken_s = ~sel_slt_s;
            3'b110:  sel_taken_s = sel_sltu_s;
            3'b111:  sel_taken_s = ~sel_sltu_s;
            default: sel_taken_s = 1'b0;
        endcase
    end

    // Output register next-state; pulses drop on stall so a held result is reported once
    always_comb begin
        out_valid_d  = 1'b0;
        taken_d      = taken_q;
        target_d     = target_q;
        redirect_d   = redirect_q;
        mispredict_d = 1'b0;
        illegal_d    = 1'b0;
        cnt_d        = cnt_q;
        if (advance_s && sel_valid_s) begin
            out_valid_d  = 1'b1;
            taken_d      = sel_taken_s;
            target_d     = sel_tgt_s;
            redirect_d   = sel_taken_s ? sel_tgt_s : sel_pc4_s;
            illegal_d    = sel_illegal_s;
            mispredict_d = ~sel_illegal_s & (sel_taken_s != sel_pred_s);
            if (mispredict_d && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= {PC_W{1'b0}};
            redirect_q   <= {PC_W{1'b0}};
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            redirect_q   <= redirect_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.taken          = taken_q;
    assign bus.target         = target_q;
    assign bus.redirect_pc    = redirect_q;
    assign bus.mispredict     = mispredict_q;
    assign bus.illegal        = illegal_q;
    assign bus.mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a 1-stage (2-bit counter) and a 2-stage instance
// share one stimulus stream and are compared against a behavioural model.
module tb_branch_resolve_unit;

    typedef struct {
        logic        v;
        logic [2:0]  f3;
        logic [63:0] rs1, rs2, pc, imm;
        logic        pred;
    } br_t;

    typedef struct {
        logic        v, taken, ill, mis;
        logic [63:0] tgt, rdr;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0, s_stall = 1'b0, s_flush = 1'b0, s_pred = 1'b0;
    logic [2:0]  s_f3 = 3'b000;
    logic [63:0] s_rs1 = 64'd0, s_rs2 = 64'd0, s_pc = 64'd0, s_imm = 64'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(64), .PC_W(64), .CNT_W(2))  if0 ();
    branch_resolve_unit_if #(.XLEN(64), .PC_W(64), .CNT_W(16)) if1 ();

    assign if0.in_valid = s_valid;   assign if1.in_valid = s_valid;
    assign if0.stall    = s_stall;   assign if1.stall    = s_stall;
    assign if0.flush    = s_flush;   assign if1.flush    = s_flush;
    assign if0.funct3   = s_f3;      assign if1.funct3   = s_f3;
    assign if0.rs1      = s_rs1;     assign if1.rs1      = s_rs1;
    assign if0.rs2      = s_rs2;     assign if1.rs2      = s_rs2;
    assign if0.pc       = s_pc;      assign if1.pc       = s_pc;
    assign if0.imm      = s_imm;     assign if1.imm      = s_imm;
    assign if0.pred_taken = s_pred;  assign if1.pred_taken = s_pred;

    branch_resolve_unit #(.XLEN(64), .PC_W(64), .STAGES(1), .CNT_W(2)) u_dut_s1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if0)
    );
    branch_resolve_unit #(.XLEN(64), .PC_W(64), .STAGES(2), .CNT_W(16)) u_dut_s2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: branch semantics straight from the ISA rules
    function automatic res_t resolve(input br_t b);
        res_t r;
        r.v   = 1'b1;
        r.ill = (b.f3 == 3'b010) || (b.f3 == 3'b011);
        case (b.f3)
            3'b000:  r.taken = (b.rs1 == b.rs2);
            3'b001:  r.taken = (b.rs1 != b.rs2);
            3'b100:  r.taken = ($signed(b.rs1) <  $signed(b.rs2));
            3'b101:  r.taken = ($signed(b.rs1) >= $signed(b.rs2));
            3'b110:  r.taken = (b.rs1 <  b.rs2);
            3'b111:  r.taken = (b.rs1 >= b.rs2);
            default: r.taken = 1'b0;
        endcase
        r.tgt = b.pc + b.imm;
        r.rdr = r.taken ? r.tgt : b.pc + 64'd4;
        r.mis = !r.ill && (r.taken != b.pred);
        return r;
    endfunction

    br_t         m_s1  [2];
    res_t        m_out [2];
    int unsigned m_cnt [2];
    int unsigned cnt_lim [2] = '{32'd3, 32'd65535};

    task automatic model_step(input int k);
        br_t  inc, head;
        res_t r;
        r = '{default: '0};
        inc.v = s_valid; inc.f3 = s_f3; inc.rs1 = s_rs1; inc.rs2 = s_rs2;
        inc.pc = s_pc; inc.imm = s_imm; inc.pred = s_pred;
        if (!rst_n) begin
            m_s1[k].v = 1'b0;
            m_out[k]  = '{default: '0};
            m_cnt[k]  = 0;
        end else if (s_flush || s_stall) begin
            if (s_flush) m_s1[k].v = 1'b0;
            m_out[k].v = 1'b0; m_out[k].mis = 1'b0; m_out[k].ill = 1'b0;
        end else begin
            head = (k == 0) ? inc : m_s1[k];
            if (head.v) begin
                r = resolve(head);
                m_out[k] = r;
                if (r.mis && m_cnt[k] < cnt_lim[k]) m_cnt[k]++;
            end else begin
                m_out[k].v = 1'b0; m_out[k].mis = 1'b0; m_out[k].ill = 1'b0;
            end
            if (k == 1) begin
                m_s1[k] = inc;
                if (head.v && r.mis) m_s1[k].v = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check_dut(input string nm, input int k, input logic [63:0] ov, tk, mp, il,
                             input logic [63:0] tg, rd, cnt);
        chk({nm, ".out_valid"}, ov, 64'(m_out[k].v));
        chk({nm, ".mispredict"}, mp, 64'(m_out[k].mis));
        chk({nm, ".illegal"}, il, 64'(m_out[k].ill));
        chk({nm, ".taken"}, tk, 64'(m_out[k].taken));
        chk({nm, ".target"}, tg, m_out[k].tgt);
        chk({nm, ".redirect_pc"}, rd, m_out[k].rdr);
        chk({nm, ".cnt"}, cnt, 64'(m_cnt[k]));
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check_dut("s1", 0, 64'(if0.out_valid), 64'(if0.taken), 64'(if0.mispredict),
                  64'(if0.illegal), if0.target, if0.redirect_pc, 64'(if0.mispredict_cnt));
        check_dut("s2", 1, 64'(if1.out_valid), 64'(if1.taken), 64'(if1.mispredict),
                  64'(if1.illegal), if1.target, if1.redirect_pc, 64'(if1.mispredict_cnt));
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [63:0] a, b, p, i,
                         input logic pr);
        s_valid = v; s_f3 = f3; s_rs1 = a; s_rs2 = b; s_pc = p; s_imm = i; s_pred = pr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_stall = 1'b0; s_flush = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        int cnt0, cnt1;
        logic [1:0]  sat_exp [5];
        logic [63:0] edge_v [5];
        logic [12:0] bi;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        edge_v  = '{64'd0, 64'd1, ALL1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};

        do_reset();
        chk("rst.out_valid", 64'(if0.out_valid), 64'd0);
        chk("rst.cnt", 64'(if1.mispredict_cnt), 64'd0);
        chk("rst.redirect", if1.redirect_pc, 64'd0);

        // signed vs unsigned compare
        drive(1'b1, 3'b100, ALL1, 64'd1, 64'h2000, 64'd16, 1'b0); cycle();
        chk("blt.taken", 64'(if0.taken), 64'd1);
        drive(1'b1, 3'b110, ALL1, 64'd1, 64'h2000, 64'd16, 1'b0); cycle();
        chk("bltu.taken", 64'(if0.taken), 64'd0);
        drive(1'b1, 3'b101, ALL1, 64'd1, 64'h2000, 64'd16, 1'b0); cycle();
        chk("bge.taken", 64'(if0.taken), 64'd0);
        drive(1'b1, 3'b111, ALL1, 64'd1, 64'h2000, 64'd16, 1'b0); cycle();
        chk("bgeu.taken", 64'(if0.taken), 64'd1);
        drive(1'b1, 3'b000, 64'd5, 64'd5, 64'h2000, 64'd16, 1'b0); cycle();
        chk("beq.taken", 64'(if0.taken), 64'd1);
        drive(1'b1, 3'b001, 64'd5, 64'd5, 64'h2000, 64'd16, 1'b0); cycle();
        chk("bne.taken", 64'(if0.taken), 64'd0);

        // target and wrap
        drive(1'b1, 3'b000, 64'd7, 64'd7, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0); cycle();
        chk("tgt.out_valid", 64'(if0.out_valid), 64'd1);
        chk("tgt.target", if0.target, 64'h0FF8);
        chk("tgt.redirect", if0.redirect_pc, 64'h0FF8);
        chk("tgt.mispredict", 64'(if0.mispredict), 64'd1);
        drive(1'b1, 3'b001, 64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd16, 1'b0); cycle();
        chk("wrap.redirect", if0.redirect_pc, 64'd0);

        // illegal funct3
        do_reset();
        drive(1'b1, 3'b010, 64'd1, 64'd1, 64'h3000, 64'd32, 1'b1); cycle();
        chk("ill.illegal", 64'(if0.illegal), 64'd1);
        chk("ill.taken", 64'(if0.taken), 64'd0);
        chk("ill.mispredict", 64'(if0.mispredict), 64'd0);
        chk("ill.cnt", 64'(if0.mispredict_cnt), 64'd0);

        // two-stage wrong-path kill
        do_reset();
        drive(1'b1, 3'b000, 64'd1, 64'd1, 64'h4000, 64'd64, 1'b0); cycle();
        chk("kill.a_early", 64'(if1.out_valid), 64'd0);
        drive(1'b1, 3'b001, 64'd1, 64'd2, 64'h4004, 64'd128, 1'b0); cycle();
        chk("kill.a_valid", 64'(if1.out_valid), 64'd1);
        chk("kill.a_mis", 64'(if1.mispredict), 64'd1);
        chk("kill.a_target", if1.target, 64'h4040);
        s_valid = 1'b0;
        cycle(); chk("kill.b_gone1", 64'(if1.out_valid), 64'd0);
        cycle(); chk("kill.b_gone2", 64'(if1.out_valid), 64'd0);

        // stall held three cycles
        do_reset();
        drive(1'b1, 3'b100, 64'd1, 64'd9, 64'h5000, 64'd8, 1'b1); cycle();
        cnt0 = int'(if0.out_valid); cnt1 = int'(if1.out_valid);
        s_valid = 1'b0; s_stall = 1'b1;
        repeat (3) begin cycle(); cnt0 += int'(if0.out_valid); cnt1 += int'(if1.out_valid); end
        s_stall = 1'b0;
        repeat (4) begin cycle(); cnt0 += int'(if0.out_valid); cnt1 += int'(if1.out_valid); end
        chk("stall.once_s1", 64'(cnt0), 64'd1);
        chk("stall.once_s2", 64'(cnt1), 64'd1);

        // flush beats stall and in_valid
        do_reset();
        drive(1'b1, 3'b000, 64'd3, 64'd3, 64'h6000, 64'd8, 1'b1); cycle();
        drive(1'b1, 3'b000, 64'd4, 64'd4, 64'h6004, 64'd8, 1'b0);
        s_flush = 1'b1; s_stall = 1'b1;
        cnt0 = 0; cnt1 = 0;
        cycle(); cnt0 += int'(if0.out_valid); cnt1 += int'(if1.out_valid);
        s_flush = 1'b0; s_stall = 1'b0; s_valid = 1'b0;
        repeat (4) begin cycle(); cnt0 += int'(if0.out_valid); cnt1 += int'(if1.out_valid); end
        chk("flush.none_s1", 64'(cnt0), 64'd0);
        chk("flush.none_s2", 64'(cnt1), 64'd0);

        // counter saturation then reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'b000, 64'd3, 64'd3, 64'h7000, 64'd8, 1'b0); cycle();
            chk($sformatf("sat.cnt%0d", i), 64'(if0.mispredict_cnt), 64'(sat_exp[i]));
        end
        rst_n = 1'b0; cycle();
        chk("sat.rst_cnt", 64'(if0.mispredict_cnt), 64'd0);
        chk("sat.rst_mis", 64'(if0.mispredict), 64'd0);
        chk("sat.rst_valid", 64'(if1.out_valid), 64'd0);
        rst_n = 1'b1; s_valid = 1'b0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_stall = ($urandom_range(0, 9) == 0);
            s_flush = ($urandom_range(0, 19) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
            s_f3    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin s_rs1 = {$urandom, $urandom}; s_rs2 = s_rs1; end
                1: begin s_rs1 = {$urandom, $urandom}; s_rs2 = {$urandom, $urandom}; end
                2: begin s_rs1 = 64'($signed(5'($urandom))); s_rs2 = 64'($signed(5'($urandom))); end
                default: begin
                    s_rs1 = edge_v[$urandom_range(0, 4)];
                    s_rs2 = edge_v[$urandom_range(0, 4)];
                end
            endcase
            s_pc  = {$urandom, $urandom} & ~64'd3;
            bi    = 13'($urandom);
            s_imm = {{51{bi[12]}}, bi[12:1], 1'b0};
            s_pred = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined branch resolution unit for the execute stage. It evaluates all six RV64I conditional-branch conditions from funct3 and computes the branch target. It compares the outcome with the fetch-stage prediction and emits a registered redirect/mispredict pulse toward fetch and the hazard unit. It generalises the single-mode equality comparator with configurable width, pipeline depth, stall/flush handling and a saturating misprediction counter.

## Interface
- XLEN, 64, operand width in bits (≥8)
- PC_W, 64, PC/immediate/target width
- STAGES, 1, pipeline depth; legal values 1 or 2
- CNT_W, 16, misprediction counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous and active-low
- in_valid  in  1  branch present on inputs this cycle
- stall  in  1  hold all stages
- flush  in  1  kill every in-flight entry
- funct3  in  3  branch type
- rs1, rs2  in  XLEN  operands
- pc  in  PC_W  branch PC
- imm  in  PC_W  sign-extended B-immediate
- pred_taken  in  1  fetch-stage prediction
- out_valid  out  1  result valid (one cycle per branch)
- taken  out  1  resolved direction
- target  out  PC_W  pc+imm
- redirect_pc  out  PC_W  taken ? target : pc+4
- mispredict  out  1  redirect fetch this cycle
- illegal  out  1  funct3 was 010 or 011
- mispredict_cnt  out  CNT_W  saturating misprediction count

## Operation
- Conditions by funct3:
  - 000 BEQ: rs1==rs2
  - 001 BNE: rs1!=rs2
  - 100 BLT: signed rs1<rs2
  - 101 BGE: signed rs1>=rs2
  - 110 BLTU: unsigned rs1<rs2
  - 111 BGEU: unsigned rs1>=rs2
- funct3 010/011: taken=0, illegal=1, mispredict=0, redirect_pc=pc+4.
- target and pc+4 wrap modulo 2^PC_W; no overflow flag.
- mispredict = out_valid & ~illegal & (taken != pred_taken).
- STAGES=1: compare, select and target are computed combinationally and registered once.
- STAGES=2:
  - Stage 1 registers eq, slt, sltu, funct3, target, pc+4 and pred_taken.
  - Stage 2 selects the outcome and registers the outputs.
- Wrong-path kill (STAGES=2): when the output register is being loaded with a mispredict, the entry moving into stage 1 that same cycle is dropped (valid cleared).
- mispredict_cnt increments by 1 on each mispredict output cycle. It saturates at all-ones and clears only on reset.
- STAGES values other than 1 or 2 are an elaboration error.

## Timing
- Latency: a branch accepted at edge N appears on the outputs after edge N+STAGES-1+1, i.e. STAGES cycles later, if there is no stall.
- Throughput: one branch per cycle.
- All outputs are registered; out_valid, mispredict and illegal are single-cycle pulses per branch.
- Reset (rst_n=0 at an edge): every stage valid, out_valid, taken, mispredict, illegal and mispredict_cnt go to 0; target and redirect_pc go to 0. Reset mid-flight discards in-flight branches.
- stall=1: all stage registers and outputs hold. out_valid is forced to 0 for the held cycles after the first, so a branch is never reported twice. The counter does not re-increment.
- flush=1: all stage valids clear at the edge, and out_valid is 0 next cycle. flush beats both stall and in_valid in the same cycle.
- in_valid=0 cycles: bubble; outputs carry out_valid=0, and the data fields are don't-care but stable.

## Test plan
- **Signed vs unsigned compare.** STAGES=1, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1:
  - BLT → taken=1, BLTU → taken=0.
  - BGE → 0, BGEU → 1.
  - BEQ/BNE on rs1=rs2=5 → 1/0.
- **Target and wrap.**
  - pc=0x1000, imm=-8, BEQ taken, pred_taken=0 → target=0x0FF8, redirect_pc=0x0FF8, mispredict=1, one cycle after the input.
  - pc=0xFFFF_FFFF_FFFF_FFFC, not taken → redirect_pc=0.
- **Illegal funct3.** funct3=010, pred_taken=1 → illegal=1, taken=0, mispredict=0, counter unchanged.
- **Two-stage pipeline, wrong-path kill.** STAGES=2, back-to-back branches A (mispredicted) and B, with B accepted the cycle A enters stage 2:
  - A's outputs appear 2 cycles after acceptance with mispredict=1.
  - B never produces out_valid.
- **Stall/flush priority.**
  - stall held for 3 cycles mid-flight → the result is reported exactly once after release.
  - flush together with stall and in_valid → no out_valid on any later cycle for those entries.
- **Counter saturation and reset.** CNT_W=2, 5 mispredicts:
  - counter reads 1, 2, 3, 3, 3.
  - rst_n low for one edge → counter 0 and all pulses 0.
